// File: rtl/mem_req_arbiter.sv
// Shares the byte-serial RAM controller request port between instruction fetch and
// load/store, issuing one latched request per grant and returning completion pulses.
module mem_req_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mc_start,
    output logic              mc_we,
    output logic [1:0]        mc_len,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    // state   | meaning
    // IDLE    | arbitrate between IF and LS
    // BUSY_IF | IF request issued, waiting for controller completion
    // BUSY_LS | LS request issued, waiting for controller completion
    // RESP_IF | if_done pulse
    // RESP_LS | ls_done pulse
    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_LS, RESP_IF, RESP_LS} state_t;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              kill;
    logic              start_pend;
    logic              done_pend;
    logic [DATA_W-1:0] rdata_pend;

    logic              if_valid;
    logic              grant_if;
    logic              grant_ls;
    logic              busy;
    logic              done_eff;
    logic [DATA_W-1:0] rdata_eff;

    assign if_valid  = if_req & ~if_flush;
    assign grant_if  = if_valid & (~ls_req | (starve_cnt == STARVE_TOP));
    assign grant_ls  = ls_req & ~grant_if;
    assign busy      = (state == BUSY_IF) || (state == BUSY_LS);
    // A completion seen while frozen is replayed from the pending latch.
    assign done_eff  = mc_done | done_pend;
    assign rdata_eff = done_pend ? rdata_pend : mc_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (grant_if)      state_nxt = BUSY_IF;
                    else if (grant_ls) state_nxt = BUSY_LS;
                end
                BUSY_IF: begin
                    if (done_eff) state_nxt = (kill | if_flush) ? IDLE : RESP_IF;
                end
                BUSY_LS: begin
                    if (done_eff) state_nxt = RESP_LS;
                end
                RESP_IF: state_nxt = IDLE;
                RESP_LS: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mc_start = start_pend & rdy_in;
        if_done  = (state == RESP_IF) & rdy_in;
        ls_done  = (state == RESP_LS) & rdy_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            kill       <= 1'b0;
            start_pend <= 1'b0;
            done_pend  <= 1'b0;
            rdata_pend <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
            mc_we      <= 1'b0;
            mc_len     <= 2'd0;
            mc_addr    <= '0;
            mc_wdata   <= '0;
        end else if (!rdy_in) begin
            if (busy && mc_done) begin
                done_pend  <= 1'b1;
                rdata_pend <= mc_rdata;
            end
        end else begin
            start_pend <= 1'b0;
            done_pend  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        mc_we      <= 1'b0;
                        mc_len     <= 2'd3;
                        mc_addr    <= if_addr;
                        mc_wdata   <= '0;
                        start_pend <= 1'b1;
                    end else if (grant_ls) begin
                        mc_we      <= ls_we;
                        mc_len     <= ls_len;
                        mc_addr    <= ls_addr;
                        mc_wdata   <= ls_wdata;
                        start_pend <= 1'b1;
                    end
                    if (grant_if || !if_valid)
                        starve_cnt <= '0;
                    else if (grant_ls && starve_cnt != STARVE_TOP)
                        starve_cnt <= starve_cnt + CNT_W'(1);
                end
                BUSY_IF: begin
                    if (done_eff) begin
                        if (kill | if_flush) kill <= 1'b0;
                        else                 if_rdata <= rdata_eff;
                    end else if (if_flush) begin
                        kill <= 1'b1;
                    end
                end
                BUSY_LS: begin
                    if (done_eff && !mc_we) ls_rdata <= rdata_eff;
                end
                RESP_IF: kill <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
